sig_liveness_watchdog: RTL

- Sits directly downstream of the load/store volume stage and consumes its full-level flag `sig`.
- Detects `sig` rising edges and measures the cycle distance between consecutive edges.
- Counts full events and tracks the maximum period seen.
- Raises `alarm` when no rising edge arrives within TIMEOUT cycles. This is the run-time counterpart of the formal "m until sig" liveness property.

---
 rtl/sig_wdog_pkg.sv | 19 +
 rtl/sat_counter.sv | 24 ++
 rtl/sig_liveness_watchdog.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/sig_wdog_pkg.sv
// rtl/sig_wdog_pkg.sv - shared state type and default sizing for the sig liveness watchdog
package sig_wdog_pkg;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        WAIT_FIRST = 2'd1,
        TRACK      = 2'd2,
        ALARM      = 2'd3
    } wdog_state_t;

    localparam int TIMEOUT_DEF = 40000;
    localparam int CBITS_DEF   = 16;
    localparam int EBITS_DEF   = 16;

    // One full load/store up/down sweep is 2*LS_N cycles plus a few of turnaround,
    // so TIMEOUT_DEF sits just above that.
    localparam int LS_N = 17500;

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - up counter with sync clear that saturates at all ones
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_clr,
    input  logic         i_inc,
    output logic [W-1:0] o_cnt
);

    logic [W-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (rst || i_clr) begin
            r_cnt <= '0;
        end else if (i_inc && (r_cnt != {W{1'b1}})) begin
            r_cnt <= r_cnt + W'(1);
        end
    end

    assign o_cnt = r_cnt;

endmodule

// File: rtl/sig_liveness_watchdog.sv
// rtl/sig_liveness_watchdog.sv - rising-edge period monitor with timeout alarm on sig
// SIG_WDOG_STICKY_ALARM_EN: when defined, ALARM holds until clear, enable low or rst.
module sig_liveness_watchdog
    import sig_wdog_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEF,
    parameter int CBITS   = CBITS_DEF,
    parameter int EBITS   = EBITS_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sig,
    input  logic             enable,
    input  logic             clear,
    output logic             alarm,
    output logic             period_valid,
    output logic [CBITS-1:0] last_period,
    output logic [CBITS-1:0] max_period,
    output logic [EBITS-1:0] event_cnt
);

    localparam logic [CBITS:0] LP_TIMEOUT = (CBITS+1)'(TIMEOUT);

    wdog_state_t      r_state;
    wdog_state_t      w_state_nxt;
    logic             r_sig_q;
    logic             r_alarm;
    logic             r_period_valid;
    logic [CBITS-1:0] r_last_period;
    logic [CBITS-1:0] r_max_period;

    logic             w_rise;
    logic [CBITS-1:0] w_timer;
    logic [CBITS:0]   w_timer_p1;
    logic             w_timeout;
    logic             w_timer_clr;
    logic             w_timer_inc;
    logic             w_cnt_inc;
    logic             w_period_upd;

    assign w_rise     = sig & ~r_sig_q;
    assign w_timer_p1 = {1'b0, w_timer} + {{CBITS{1'b0}}, 1'b1};
    assign w_timeout  = w_timer_p1 > LP_TIMEOUT;
    assign w_timer_inc = (r_state != IDLE) && !w_timer_clr;

    sat_counter #(.W(CBITS)) u_timer (
        .clk   (clk),
        .rst   (rst),
        .i_clr (w_timer_clr),
        .i_inc (w_timer_inc),
        .o_cnt (w_timer)
    );

    sat_counter #(.W(EBITS)) u_event_cnt (
        .clk   (clk),
        .rst   (rst),
        .i_clr (clear),
        .i_inc (w_cnt_inc),
        .o_cnt (event_cnt)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_timer_clr  = 1'b0;
        w_cnt_inc    = 1'b0;
        w_period_upd = 1'b0;
        if (clear) begin
            w_state_nxt = enable ? WAIT_FIRST : IDLE;
            w_timer_clr = 1'b1;
        end else if (!enable) begin
            w_state_nxt = IDLE;
            w_timer_clr = 1'b1;
        end else begin
            unique case (r_state)
                IDLE: begin
                    w_state_nxt = WAIT_FIRST;
                    w_timer_clr = 1'b1;
                end
                WAIT_FIRST: begin
                    if (w_rise) begin
                        w_state_nxt = TRACK;
                        w_cnt_inc   = 1'b1;
                        w_timer_clr = 1'b1;
                    end else if (w_timeout) begin
                        w_state_nxt = ALARM;
                    end
                end
                TRACK: begin
                    if (w_rise) begin
                        w_cnt_inc    = 1'b1;
                        w_period_upd = 1'b1;
                        w_timer_clr  = 1'b1;
                    end else if (w_timeout) begin
                        w_state_nxt = ALARM;
                    end
                end
                ALARM: begin
                    if (w_rise) begin
                        w_cnt_inc = 1'b1;
`ifdef SIG_WDOG_STICKY_ALARM_EN
                        w_state_nxt = ALARM;
`else
                        w_state_nxt = TRACK;
                        w_timer_clr = 1'b1;
`endif
                    end
                end
                default: w_state_nxt = IDLE;
            endcase
        end
    end

    // sig_q keeps sampling while disabled so re-arming with sig already high is not an edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sig_q        <= 1'b0;
            r_alarm        <= 1'b0;
            r_period_valid <= 1'b0;
            r_last_period  <= '0;
            r_max_period   <= '0;
        end else begin
            r_sig_q        <= sig;
            r_alarm        <= (w_state_nxt == ALARM);
            r_period_valid <= w_period_upd;
            if (clear) begin
                r_last_period <= '0;
                r_max_period  <= '0;
            end else if (w_period_upd) begin
                r_last_period <= w_timer_p1[CBITS-1:0];
                if (w_timer_p1[CBITS-1:0] > r_max_period) begin
                    r_max_period <= w_timer_p1[CBITS-1:0];
                end
            end
        end
    end

    assign alarm        = r_alarm;
    assign period_valid = r_period_valid;
    assign last_period  = r_last_period;
    assign max_period   = r_max_period;

endmodule
